imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pkg.sv | 19 +
 rtl/imm_ext_comb.sv | 30 +++
 rtl/imm_ext_pipe.sv | 66 ++++++
 tb/tb_imm_ext_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: extension mode encodings and instruction field positions
package imm_ext_pkg;
    typedef enum logic [2:0] {
        EXT_ZERO   = 3'd0,
        EXT_LUI    = 3'd1,
        EXT_SIGN16 = 3'd2,
        EXT_SIGN9  = 3'd3,
        EXT_BR     = 3'd4,
        EXT_JMP    = 3'd5,
        EXT_SHAMT  = 3'd6,
        EXT_ILL    = 3'd7
    } ext_op_e;
    localparam int IMM16_HI = 15;
    localparam int IMM9_HI  = 8;
    localparam int JMP_HI   = 25;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int PC_LO    = 28;
endpackage

// File: rtl/imm_ext_comb.sv
// imm_ext_comb: combinational immediate extraction and extension
module imm_ext_comb
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        ext_op,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] imm,
    output logic              err
);
    // instr[31:26] and the low PC bits never reach the result
    logic unused_bits;
    assign unused_bits = ^{instr[31:JMP_HI+1], pc_plus4[PC_LO-1:0]};
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (ext_op_e'(ext_op))
            EXT_ZERO:   imm = DATA_W'(instr[IMM16_HI:0]);
            EXT_LUI:    imm = DATA_W'($signed({instr[IMM16_HI:0], 16'h0000}));
            EXT_SIGN16: imm = DATA_W'($signed(instr[IMM16_HI:0]));
            EXT_SIGN9:  imm = DATA_W'($signed(instr[IMM9_HI:0]));
            EXT_BR:     imm = DATA_W'($signed({instr[IMM16_HI:0], 2'b00}));
            EXT_JMP:    imm = {pc_plus4[DATA_W-1:PC_LO], instr[JMP_HI:0], 2'b00};
            EXT_SHAMT:  imm = DATA_W'(instr[SHAMT_HI:SHAMT_LO]);
            default:    err = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: valid/ready pipeline of STAGES registers around imm_ext_comb
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ext_op,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_imm,
    output logic              op_err
);
    localparam int W = DATA_W + 1;
    logic [DATA_W-1:0]          c_imm;
    logic                       c_err;
    logic                       fire;
    logic [STAGES-1:0]          v, ld, src_v;
    logic [STAGES-1:0][W-1:0]   d, src_d;

    imm_ext_comb #(.DATA_W(DATA_W)) u_comb (
        .ext_op   (ext_op),
        .instr    (instr),
        .pc_plus4 (pc_plus4),
        .imm      (c_imm),
        .err      (c_err)
    );

    // a stage may load unless it and every stage downstream are full and stalled
    for (genvar s = 0; s < STAGES; s++) begin : g_ld
        assign ld[s] = out_ready || !(&v[STAGES-1:s]);
    end

    assign in_ready = rst_n && !flush && ld[0];
    assign fire     = in_valid && in_ready;

    if (STAGES == 1) begin : g_one
        assign src_v = fire;
        assign src_d = {c_err, c_imm};
    end else begin : g_many
        assign src_v = {v[STAGES-2:0], fire};
        assign src_d = {d[STAGES-2:0], c_err, c_imm};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) v <= '0;
        else v <= (v & ~ld) | (src_v & ld);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (ld[i]) d[i] <= src_d[i];
        end
    end

    // reset gates the output so nothing transfers in the reset cycle
    assign out_valid         = rst_n && v[STAGES-1];
    assign {op_err, ext_imm} = out_valid ? d[STAGES-1] : '0;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed checks on three configurations of imm_ext_pipe
module tb_imm_ext_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A: DATA_W=32, STAGES=1
    logic        a_rst_n = 1'b0, a_in_valid = 1'b0, a_flush = 1'b0, a_out_ready = 1'b1;
    logic        a_in_ready, a_out_valid, a_op_err;
    logic [2:0]  a_ext_op = '0;
    logic [31:0] a_instr = '0, a_pc = 32'h9000_0004, a_ext_imm;
    imm_ext_pipe #(.DATA_W(32), .STAGES(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .ext_op(a_ext_op), .instr(a_instr), .pc_plus4(a_pc), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .ext_imm(a_ext_imm), .op_err(a_op_err)
    );

    // B: DATA_W=64, STAGES=2
    logic        b_rst_n = 1'b0, b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b1;
    logic        b_in_ready, b_out_valid, b_op_err;
    logic [2:0]  b_ext_op = '0;
    logic [31:0] b_instr = '0;
    logic [63:0] b_pc = '0, b_ext_imm;
    imm_ext_pipe #(.DATA_W(64), .STAGES(2)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .ext_op(b_ext_op), .instr(b_instr), .pc_plus4(b_pc), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .ext_imm(b_ext_imm), .op_err(b_op_err)
    );

    // C: DATA_W=32, STAGES=3
    logic        c_rst_n = 1'b0, c_in_valid = 1'b0, c_flush = 1'b0, c_out_ready = 1'b1;
    logic        c_in_ready, c_out_valid, c_op_err;
    logic [2:0]  c_ext_op = '0;
    logic [31:0] c_instr = '0, c_pc = '0, c_ext_imm;
    imm_ext_pipe #(.DATA_W(32), .STAGES(3)) u_c (
        .clk(clk), .rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .ext_op(c_ext_op), .instr(c_instr), .pc_plus4(c_pc), .flush(c_flush),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .ext_imm(c_ext_imm), .op_err(c_op_err)
    );

    localparam int NA = 10;
    logic [2:0]  a_ops [NA] = '{3'd2, 3'd5, 3'd7, 3'd6, 3'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4};
    logic [31:0] a_ins [NA] = '{32'h0000_8001, 32'h0000_0010, 32'hFFFF_FFFF, 32'hABC0_07C0, 32'h1234_F00F,
                                32'h0000_8000, 32'h0000_0100, 32'h0000_00FF, 32'h0000_FFFF, 32'h0000_0004};
    logic [31:0] a_exp [NA] = '{32'hFFFF_8001, 32'h9000_0040, 32'h0, 32'h1F, 32'h0000_F00F,
                                32'h8000_0000, 32'hFFFF_FF00, 32'h0000_00FF, 32'hFFFF_FFFC, 32'h10};
    logic        a_err [NA] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    localparam int NB = 4;
    logic [2:0]  b_ops [NB] = '{3'd1, 3'd5, 3'd7, 3'd2};
    logic [31:0] b_ins [NB] = '{32'h0000_8000, 32'h03FF_FFFF, 32'hFFFF_FFFF, 32'h0000_7FFF};
    logic [63:0] b_pcs [NB] = '{64'h0, 64'h1234_5678_9ABC_DEF4, 64'h0, 64'h0};
    logic [63:0] b_exp [NB] = '{64'hFFFF_FFFF_8000_0000, 64'h1234_5678_9FFF_FFFC, 64'h0, 64'h7FFF};
    logic        b_err [NB] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // C: index of the result shown each cycle (-1 = none) and in_ready for cycles 0..8
    int   c_out_tab [13] = '{-1, -1, -1, 0, 1, 1, 1, 1, 1, 2, 3, 4, -1};
    logic c_ir_tab  [9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic b_drive(input int k);
        b_in_valid = 1'b1;
        b_ext_op   = b_ops[k];
        b_instr    = b_ins[k];
        b_pc       = b_pcs[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int ri;
        repeat (2) next_cycle();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        c_rst_n = 1'b1;
        @(negedge clk);
        check("a_rst_out_valid", a_out_valid, 0);
        check("a_rst_in_ready", a_in_ready, 1);
        check("a_rst_ext_imm", a_ext_imm, 0);
        check("a_rst_op_err", a_op_err, 0);
        check("b_rst_out_valid", b_out_valid, 0);
        check("c_rst_in_ready", c_in_ready, 1);
        next_cycle();

        // A: every mode back-to-back, one-cycle latency, full throughput
        for (int c = 0; c <= NA; c++) begin
            a_in_valid = c < NA;
            if (c < NA) begin
                a_ext_op = a_ops[c];
                a_instr  = a_ins[c];
            end
            @(negedge clk);
            check("a_in_ready", a_in_ready, 1);
            check("a_out_valid", a_out_valid, c > 0);
            if (c > 0) begin
                check("a_ext_imm", a_ext_imm, a_exp[c-1]);
                check("a_op_err", a_op_err, a_err[c-1]);
            end
            next_cycle();
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        check("a_idle_out_valid", a_out_valid, 0);
        check("a_idle_ext_imm", a_ext_imm, 0);
        next_cycle();

        // A: backpressure holds the output and blocks input
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_ext_op    = 3'd2;
        a_instr     = 32'h0000_8001;
        next_cycle();
        a_ext_op = 3'd0;
        a_instr  = 32'h0000_5555;
        @(negedge clk);
        check("a_bp_imm", a_ext_imm, 32'hFFFF_8001);
        check("a_bp_in_ready", a_in_ready, 0);
        next_cycle();
        @(negedge clk);
        check("a_bp_hold", a_ext_imm, 32'hFFFF_8001);
        check("a_bp_hold_valid", a_out_valid, 1);
        a_out_ready = 1'b1;
        #1;
        check("a_bp_release_ready", a_in_ready, 1);
        next_cycle();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("a_bp_next_imm", a_ext_imm, 32'h0000_5555);
        next_cycle();
        @(negedge clk);
        check("a_bp_drained", a_out_valid, 0);
        next_cycle();

        // B: 64-bit modes with two-cycle latency
        for (int c = 0; c <= NB + 2; c++) begin
            if (c < NB) b_drive(c);
            else b_in_valid = 1'b0;
            @(negedge clk);
            check("b_in_ready", b_in_ready, 1);
            check("b_out_valid", b_out_valid, c >= 2 && c < NB + 2);
            if (c >= 2 && c < NB + 2) begin
                check("b_ext_imm", b_ext_imm, b_exp[c-2]);
                check("b_op_err", b_op_err, b_err[c-2]);
            end
            next_cycle();
        end

        // B: fill both stages, then flush with a pending input
        b_out_ready = 1'b0;
        b_drive(3);
        next_cycle();
        b_drive(0);
        next_cycle();
        b_drive(1);
        b_flush = 1'b1;
        @(negedge clk);
        check("b_full_out_valid", b_out_valid, 1);
        check("b_full_imm", b_ext_imm, 64'h7FFF);
        check("b_flush_in_ready", b_in_ready, 0);
        next_cycle();
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        @(negedge clk);
        check("b_post_flush_valid", b_out_valid, 0);
        check("b_post_flush_ready", b_in_ready, 1);
        check("b_post_flush_imm", b_ext_imm, 0);
        next_cycle();
        @(negedge clk);
        check("b_flush_no_accept", b_out_valid, 0);
        next_cycle();

        // B: reset with two results in flight
        b_out_ready = 1'b0;
        b_drive(0);
        next_cycle();
        b_drive(3);
        next_cycle();
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_inflight_valid", b_out_valid, 1);
        b_rst_n     = 1'b0;
        b_out_ready = 1'b1;
        #1;
        check("b_rst_cycle_valid", b_out_valid, 0);
        next_cycle();
        b_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("b_after_rst_valid", b_out_valid, 0);
            check("b_after_rst_ready", b_in_ready, 1);
            next_cycle();
        end

        // C: five requests, output stalled in cycles 4..7
        ri = 0;
        for (int c = 0; c < 13; c++) begin
            c_out_ready = !(c >= 4 && c <= 7);
            c_in_valid  = ri < 5;
            c_instr     = 32'h1000 + ri;
            @(negedge clk);
            if (c <= 8) check("c_in_ready", c_in_ready, c_ir_tab[c]);
            check("c_out_valid", c_out_valid, c_out_tab[c] >= 0);
            if (c_out_tab[c] >= 0) check("c_ext_imm", c_ext_imm, 32'h1000 + c_out_tab[c]);
            if (c_in_valid && c_in_ready) ri++;
            next_cycle();
        end
        check("c_all_accepted", ri, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
